// File: rtl/c432_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// c432_pattern_sequencer_if
//   Bundles the host control/status signals of the pattern sequencer with
//   the stimulus/response pair that connects to the c432 core wrapper.
//
//   Host -> sequencer : start, abort, num_patterns, seed, golden_sig
//   Wrapper -> seq.   : dut_out (7-bit core response)
//   Sequencer -> out  : dut_in (36-bit vector), busy, done, pass,
//                       signature, pattern_count
//
//   master : host/wrapper side (drives controls and dut_out)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface c432_pattern_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_patterns;
    logic [35:0]      seed;
    logic [6:0]       golden_sig;
    logic [35:0]      dut_in;
    logic [6:0]       dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [6:0]       signature;
    logic [CNT_W-1:0] pattern_count;

    modport master (
        output start, abort, num_patterns, seed, golden_sig, dut_out,
        input  dut_in, busy, done, pass, signature, pattern_count
    );

    modport slave (
        input  start, abort, num_patterns, seed, golden_sig, dut_out,
        output dut_in, busy, done, pass, signature, pattern_count
    );
endinterface

// File: rtl/c432_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// c432_pattern_sequencer
//   Self-test run controller for the c432 core. An LFSR produces 36-bit
//   vectors on dut_in; each vector is held for SETTLE_CYCLES+2 cycles and the
//   7-bit response on dut_out is folded into a MISR on the last cycle. When
//   num_patterns responses have been captured the run ends in DONE, where
//   pass reports signature == golden_sig.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : slave modport (start/abort/num_patterns/seed/golden_sig in,
//             dut_in out, dut_out in, busy/done/pass/signature/
//             pattern_count out)
// ---------------------------------------------------------------------------
module c432_pattern_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    c432_pattern_sequencer_if.slave bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] APPLY   = 3'd2;
    localparam logic [2:0] SETTLE  = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    // The settle counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    logic [2:0]       state_q,  state_d;
    logic [35:0]      dut_in_q, dut_in_d;
    logic [6:0]       sig_q,    sig_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] num_q,    num_d;
    logic [35:0]      seed_q,   seed_d;
    logic [SET_W-1:0] settle_q, settle_d;

    logic             busy_w;
    logic [CNT_W-1:0] count_inc;
    logic [35:0]      lfsr_next;
    logic [6:0]       misr_next;

    assign busy_w    = (state_q == LOAD) || (state_q == APPLY) ||
                       (state_q == SETTLE) || (state_q == CAPTURE);
    assign count_inc = count_q + 1'b1;
    assign lfsr_next = {dut_in_q[34:0], dut_in_q[35] ^ dut_in_q[24]};
    assign misr_next = {sig_q[5:0], sig_q[6] ^ sig_q[5]} ^ bus.dut_out;

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        sig_d    = sig_q;
        count_d  = count_q;
        num_d    = num_q;
        seed_d   = seed_q;
        settle_d = settle_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Run settings are captured at the start edge so that
                    // later changes on the host inputs cannot leak in.
                    num_d  = bus.num_patterns;
                    seed_d = bus.seed;
                    if (bus.num_patterns == '0) begin
                        state_d = DONE;
                        sig_d   = '0;
                        count_d = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // An all-zero seed would lock the LFSR at zero.
                dut_in_d = (seed_q == 36'h0) ? 36'h1 : seed_q;
                sig_d    = '0;
                count_d  = '0;
                state_d  = APPLY;
            end
            APPLY: begin
                if (SETTLE_CYCLES > 0) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end else begin
                    state_d  = CAPTURE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            CAPTURE: begin
                sig_d    = misr_next;
                count_d  = count_inc;
                dut_in_d = lfsr_next;
                state_d  = (count_inc == num_q) ? DONE : APPLY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort freezes the datapath where it is and returns to IDLE; it
        // overrides everything, including the final CAPTURE.
        if (bus.abort && busy_w) begin
            state_d  = IDLE;
            dut_in_d = dut_in_q;
            sig_d    = sig_q;
            count_d  = count_q;
            settle_d = settle_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dut_in_q <= '0;
            sig_q    <= '0;
            count_q  <= '0;
            num_q    <= '0;
            seed_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            sig_q    <= sig_d;
            count_q  <= count_d;
            num_q    <= num_d;
            seed_q   <= seed_d;
            settle_q <= settle_d;
        end
    end

    assign bus.dut_in        = dut_in_q;
    assign bus.busy          = busy_w;
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = (state_q == DONE) && (sig_q == bus.golden_sig);
    assign bus.signature     = sig_q;
    assign bus.pattern_count = count_q;

endmodule
